// File: rtl/alu_pkg.sv
// Shared ALU constants: Signal codes, operand width and the divider state encoding.
package alu_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] DIV   = 6'b011010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    assign trial = {rem_i, quo_i[WIDTH-1]};
    assign fits  = trial >= {1'b0, divisor_i};
    assign diff  = trial - {1'b0, divisor_i};

    // The remainder stays below the divisor, so the top bit drops out either way.
    assign rem_o = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/divider.sv
// Iterative 32-bit restoring divider for the HI/LO path: dataOut = {remainder, quotient}.
// Define DIVIDER_SIGNED_EN to also accept the signed DIV code with sign fix-up.
module divider
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    div_state_e          state_q;
    logic [4:0]          cnt_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quo_q;
    logic [WIDTH-1:0]    divisor_q;
    logic                busy_q;
    logic                done_q;
    logic [2*WIDTH-1:0]  data_out_q;

    logic [WIDTH-1:0]    rem_d;
    logic [WIDTH-1:0]    quo_d;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [WIDTH-1:0]    quo_fin;
    logic [WIDTH-1:0]    rem_fin;
    logic                code_ok;
    logic                accept;

`ifdef DIVIDER_SIGNED_EN
    logic                qneg;
    logic                rneg;
    logic                qneg_q;
    logic                rneg_q;

    assign code_ok = (Signal == DIVU) || (Signal == DIV);
`else
    assign code_ok = (Signal == DIVU);
`endif

    assign accept = start && code_ok && (state_q != RUN);

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Operand magnitudes and sign flags; a zero divisor runs unsigned so the remainder is dataA.
    always_comb begin
        a_mag = dataA;
        b_mag = dataB;
`ifdef DIVIDER_SIGNED_EN
        qneg  = 1'b0;
        rneg  = 1'b0;
        if (Signal == DIV && dataB != '0) begin
            a_mag = dataA[WIDTH-1] ? WIDTH'(-dataA) : dataA;
            b_mag = dataB[WIDTH-1] ? WIDTH'(-dataB) : dataB;
            qneg  = dataA[WIDTH-1] ^ dataB[WIDTH-1];
            rneg  = dataA[WIDTH-1];
        end
`endif
    end

    always_comb begin
        quo_fin = quo_d;
        rem_fin = rem_d;
`ifdef DIVIDER_SIGNED_EN
        if (qneg_q) quo_fin = WIDTH'(-quo_d);
        if (rneg_q) rem_fin = WIDTH'(-rem_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        data_out_q <= {rem_fin, quo_fin};
                    end
                end
                default: begin
                    if (accept) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= a_mag;
                        divisor_q <= b_mag;
`ifdef DIVIDER_SIGNED_EN
                        qneg_q    <= qneg;
                        rneg_q    <= rneg;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataOut = data_out_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (signed cases compile in with DIVIDER_SIGNED_EN).
module tb_divider;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        done;
    logic [63:0] dataOut;

    int n_checks = 0;
    int n_errors = 0;

    divider dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for done, counting busy cycles; returns at the done cycle's negedge.
    task automatic wait_done(output int busy_cycles, output logic got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    // Issue one start pulse at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = sig;
        dataA  = a;
        dataB  = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] sig, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int   cyc;
        logic ok;
        issue(sig, a, b);
        wait_done(cyc, ok);
        check({tag, "_done"}, 64'(ok), 64'd1);
        check({tag, "_data"}, dataOut, exp);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
        @(negedge clk);
    endtask

    initial begin
        int   cyc;
        logic ok;
        reset  = 1'b1;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = DIVU;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", dataOut, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic divide with handshake shape
        issue(DIVU, 32'd100, 32'd7);
        check("basic_busy_after_accept", 64'(busy), 64'd1);
        wait_done(cyc, ok);
        check("basic_done", 64'(ok), 64'd1);
        check("basic_busy_cycles", 64'(cyc), 64'd32);
        check("basic_busy_in_done", 64'(busy), 64'd0);
        check("basic_data", dataOut, 64'h0000_0002_0000_000E);
        @(negedge clk);
        check("basic_done_one_cycle", 64'(done), 64'd0);
        check("basic_data_held", dataOut, 64'h0000_0002_0000_000E);

        run_op("div0", DIVU, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF);
        run_op("max_by_1", DIVU, 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF);

        // Non-divide code is ignored
        issue(MULTU, 32'd10, 32'd2);
        check("multu_ignored", 64'(busy), 64'd0);

        // Back-to-back: start during RUN is ignored, start in DONE is accepted
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        issue(DIVU, 32'd9, 32'd4);
        wait_done(cyc, ok);
        check("b2b_first_done", 64'(ok), 64'd1);
        check("b2b_first_cycles", 64'(cyc), 64'd26);
        check("b2b_first_data", dataOut, 64'h0000_0002_0000_000E);
        issue(DIVU, 32'd9, 32'd4);
        check("b2b_second_busy", 64'(busy), 64'd1);
        check("b2b_second_done_low", 64'(done), 64'd0);
        check("b2b_data_held_in_run", dataOut, 64'h0000_0002_0000_000E);
        wait_done(cyc, ok);
        check("b2b_second_done", 64'(ok), 64'd1);
        check("b2b_second_cycles", 64'(cyc), 64'd32);
        check("b2b_second_data", dataOut, 64'h0000_0001_0000_0002);
        @(negedge clk);

        // Reset during the 10th RUN cycle
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_data", dataOut, 64'h0);
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", 64'(busy), 64'd0);
        run_op("after_rst", DIVU, 32'd50, 32'd5, 64'h0000_0000_0000_000A);

`ifdef DIVIDER_SIGNED_EN
        run_op("sdiv_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("sdiv_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("sdiv_div0", DIV, 32'hFFFF_FFF9, 32'h0, 64'hFFFF_FFF9_FFFF_FFFF);
        run_op("sdiv_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
`else
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_ignored_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("div_ignored_busy_later", 64'(busy), 64'd0);
        check("div_ignored_data", dataOut, 64'h0000_0000_0000_000A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
